// File: rtl/seg7_scan_display.sv
// seg7_scan_display: captures the core output on each instruction commit
// and scans it onto a 4-digit multiplexed hex seven-segment display.
module seg7_scan_display #(
  parameter int SCAN_DIV   = 50000,
  parameter int ACTIVE_LOW = 1,
  parameter int BLANK_LZ   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  phase,
  input  logic [15:0] out_val,
  input  logic        freeze,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic [15:0] shown,
  output logic        commit_pulse
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam bit INV = (ACTIVE_LOW != 0);
  localparam bit BLZ = (BLANK_LZ != 0);
  localparam logic [6:0] SEG_OFF = INV ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_OFF  = INV ? 4'hF : 4'h0;
  localparam logic DP_OFF = INV;

  logic [2:0]    prev_phase;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          hb;
  logic          take;
  logic [3:0]    nib;
  logic [3:0]    blank;
  logic          lit;
  logic [6:0]    seg_hi;
  logic [6:0]    seg_n;
  logic [3:0]    an_n;
  logic          dp_n;

  // A commit is the 5 -> 0 phase transition; freeze drops it entirely
  assign take = (prev_phase == 3'd5) && (phase == 3'd0) && !freeze;

  // Capture register, commit strobe and heartbeat
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_phase   <= '0;
      shown        <= '0;
      commit_pulse <= 1'b0;
      hb           <= 1'b0;
    end else begin
      prev_phase   <= phase;
      commit_pulse <= take;
      if (take) begin
        shown <= out_val;
        hb    <= ~hb;
      end
    end
  end

  // Slot prescaler; the digit index advances on each wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Active-high drive for the current slot: guard, blanking, decode
  always_comb begin
    nib    = shown[{idx, 2'b00} +: 4];
    blank  = 4'b0000;
    seg_hi = 7'h00;
    if (BLZ) begin
      blank[3] = (shown[15:12] == 4'h0);
      blank[2] = blank[3] && (shown[11:8] == 4'h0);
      blank[1] = blank[2] && (shown[7:4] == 4'h0);
    end
    lit = (cnt != '0) && !blank[idx];
    unique case (nib)
      4'h0: seg_hi = 7'h3F;
      4'h1: seg_hi = 7'h06;
      4'h2: seg_hi = 7'h5B;
      4'h3: seg_hi = 7'h4F;
      4'h4: seg_hi = 7'h66;
      4'h5: seg_hi = 7'h6D;
      4'h6: seg_hi = 7'h7D;
      4'h7: seg_hi = 7'h07;
      4'h8: seg_hi = 7'h7F;
      4'h9: seg_hi = 7'h6F;
      4'hA: seg_hi = 7'h77;
      4'hB: seg_hi = 7'h7C;
      4'hC: seg_hi = 7'h39;
      4'hD: seg_hi = 7'h5E;
      4'hE: seg_hi = 7'h79;
      4'hF: seg_hi = 7'h71;
    endcase
    seg_n = lit ? seg_hi : 7'h00;
    an_n  = lit ? (4'b0001 << idx) : 4'b0000;
    dp_n  = lit && (idx == 2'd0) && hb;
  end

  // Registered pin drive; XOR with the off pattern applies polarity
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_OFF;
      an  <= AN_OFF;
      dp  <= DP_OFF;
    end else begin
      seg <= seg_n ^ SEG_OFF;
      an  <= an_n ^ AN_OFF;
      dp  <= dp_n ^ DP_OFF;
    end
  end

endmodule

// File: doc/seg7_scan_display.md
# seg7_scan_display

Downstream output stage for the 16-bit processor core. It samples the core's 16-bit `out` value (the AR contents) when an instruction completes, at the phase 5 → phase 0 transition. It then drives a 4-digit multiplexed hex seven-segment display with leading-zero blanking, an inter-digit ghosting guard and a per-instruction heartbeat on the decimal point. It sits between the core top level and the board display pins.

## Interface
- `SCAN_DIV`, default 50000: clock cycles per digit slot; legal range ≥ 2.
- `ACTIVE_LOW`, default 1: when 1, `seg`, `dp` and `an` are active-low; when 0, active-high.
- `BLANK_LZ`, default 1: when 1, leading zeros are blanked.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `phase`, input, 3: core phase counter (0 = idle/initial, 1..5 = execution phases).
- `out_val`, input, 16: core output value.
- `freeze`, input, 1: when high, suppresses capture and holds the displayed value.
- `seg`, output, 7: segment drive, bit0 = a … bit6 = g.
- `dp`, output, 1: decimal point drive.
- `an`, output, 4: digit enables, one-hot, bit0 = rightmost digit.
- `shown`, output, 16: currently latched display value.
- `commit_pulse`, output, 1: one-cycle strobe per capture.

## Operation
- **Commit detect:** `prev_phase` register holds last cycle's `phase`. A commit is `prev_phase == 5` AND `phase == 0`. Other transitions, including 0 → 0 idle, do not capture.
- **Capture:** on commit with `freeze` = 0:
  - `shown` ← `out_val`.
  - `commit_pulse` ← 1 for exactly one cycle.
  - `hb` (heartbeat flop) toggles.
- Commit with `freeze` = 1: no capture, no pulse, no toggle; the event is lost, not deferred.
- **Prescaler:** `cnt` counts 0..`SCAN_DIV`−1 and wraps. On wrap, digit index `idx` advances 0 → 1 → 2 → 3 → 0.
- **Digit data:** digit `idx` shows `shown[4*idx+3 : 4*idx]`.
- **Hex encoding** (active-high, gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71. When `ACTIVE_LOW` = 1, `seg`, `dp` and `an` are bitwise inverted.
- **Leading-zero blanking** (`BLANK_LZ` = 1):
  - Digit k ∈ {3, 2, 1} is blanked when nibbles k..3 are all zero.
  - Digit 0 is never blanked; value 0 shows a single "0".
  - A blanked digit has `an` inactive and `seg` all off.
- **Ghost guard:** in the first cycle of every digit slot (`cnt` == 0), `an` is all inactive and `seg` is all off.
- **Decimal point:** lit only while digit 0 is active and `hb` = 1; off on all other digits.
- **Register boundaries:** `seg`, `dp`, `an` and `commit_pulse` are registered outputs. `shown` is the capture register itself.
- **Reset values:**
  - Internal state: `prev_phase` = 0, `cnt` = 0, `idx` = 0, `hb` = 0.
  - Outputs: `shown` = 0x0000, `commit_pulse` = 0, `an` = all inactive, `seg` = all off, `dp` = off. Inactive/off means 1s when `ACTIVE_LOW` = 1, 0s when `ACTIVE_LOW` = 0.
- **Reset mid-scan or mid-commit:** all state returns to reset values in the cycle after `rst` is sampled high. A commit coinciding with `rst` is discarded. `prev_phase` is cleared, so a phase 0 sampled right after reset does not trigger capture.

## Timing
- **Capture latency:** commit condition sampled at edge E makes `shown` and `commit_pulse` valid after E. `commit_pulse` drops after E+1.
- **Display latency:** a new `shown` reaches `seg` at the next edge on which the currently active digit is evaluated, within at most 1 cycle once its slot is active. Full refresh is at most 4·`SCAN_DIV` + 1 cycles.
- **Slot structure:** each slot is `SCAN_DIV` cycles, 1 guard cycle plus `SCAN_DIV`−1 lit cycles. Frame = 4·`SCAN_DIV` cycles; `idx` wraps 3 → 0 with no extra cycles.
- **Successive commits:** back-to-back commits (at most one per 6 cycles from the core) each capture and pulse independently.
- **Capture vs. scan:** a capture on the same edge as a slot change is honoured; the new slot shows the new value.

## Test plan
- **Reset:** `SCAN_DIV`=4, `ACTIVE_LOW`=1; assert `rst` 2 cycles → `an`=4'b1111, `seg`=7'h7F, `dp`=1, `shown`=0, `commit_pulse`=0.
- **Capture:** drive `phase` 1..5 then 0 with `out_val`=16'h12AF → `shown`=16'h12AF one edge after phase-0 sample, `commit_pulse` high exactly 1 cycle. Across one frame the digits show F(71), A(77), 2(5B), 1(06), each inverted, in `an` order 1110, 1101, 1011, 0111. Each slot is 1 guard cycle plus 3 lit cycles.
- **Blanking:** capture 16'h0005 → only digit 0 is lit, with `seg`=~7'h6D; digits 1–3 keep `an` inactive. Capture 16'h0000 → digit 0 shows ~7'h3F. With `BLANK_LZ`=0, 16'h0005 lights all four digits, showing 0, 0, 0, 5.
- **Freeze:** `freeze`=1 during a commit with `out_val`=16'hBEEF → `shown` unchanged, no pulse, `hb` unchanged. Release `freeze`; the next commit captures normally.
- **Heartbeat:** three commits → `hb` goes 1, 0, 1; `dp` is low (lit) only during digit-0 lit cycles when `hb`=1.
- **Mid-operation reset:** `rst` pulsed on the same cycle as a commit during digit-2 slot → `shown`=0, `idx`=0, `cnt`=0, no `commit_pulse`. No capture occurs on the following phase-0 cycle.
